// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
// Holds state encodings, hazard causes, the control bundle and the register-match helper.
`ifndef ZERO_WORD
`define ZERO_WORD 16'h0000
`endif

package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_JR_WAIT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_FREEZE,
        CAUSE_REDIRECT,
        CAUSE_JR_WAIT,
        CAUSE_LOAD_USE,
        CAUSE_JR_HAZ,
        CAUSE_JUMP,
        CAUSE_IMISS
    } cause_e;

    typedef struct packed {
        logic stall_f;
        logic fcd;
        logic b2;
        logic flush_e;
        logic stall_em;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '0;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic en,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
        return en && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            count_q <= WIDTH'(`ZERO_WORD);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I core: stalls, bubbles and whole-pipe
// freezes, with a two-state register covering the second jalr-after-load stall cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic             is_jjru_d,
    input  logic             is_jr_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             wr_e,
    input  logic             is_load_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic             is_load_m,
    input  logic             branch_taken_e,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             fcD,
    output logic             b2,
    output logic             flush_e,
    output logic             stall_em,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e state_q;
    state_e state_d;
    cause_e cause;
    ctl_t   ctl;

    logic hit_e_rs1;
    logic hit_e_rs2;
    logic hit_m_rs1;
    logic load_use;
    logic jr_haz;
    logic flush_any;

    assign hit_e_rs1 = reg_hit(wr_e, rd_e, rs1_d);
    assign hit_e_rs2 = reg_hit(wr_e, rd_e, rs2_d);
    assign hit_m_rs1 = reg_hit(is_load_m, rd_m, rs1_d);

    assign load_use = is_load_e && ((use_rs1_d && hit_e_rs1) || (use_rs2_d && hit_e_rs2));
    // jalr resolves its target in ID, so even an ALU result in EX is too late for it.
    assign jr_haz   = is_jr_d && ((hit_e_rs1 && !is_load_e) || hit_m_rs1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        cause   = CAUSE_NONE;
        state_d = state_q;
        if (!dmem_ready) begin
            cause = CAUSE_FREEZE;
        end else if (branch_taken_e) begin
            cause   = CAUSE_REDIRECT;
            state_d = ST_RUN;
        end else if (state_q == ST_JR_WAIT) begin
            cause   = CAUSE_JR_WAIT;
            state_d = ST_RUN;
        end else if (load_use) begin
            cause   = CAUSE_LOAD_USE;
            state_d = is_jr_d ? ST_JR_WAIT : ST_RUN;
        end else if (jr_haz) begin
            cause   = CAUSE_JR_HAZ;
            state_d = ST_RUN;
        end else if (is_jjru_d) begin
            cause   = CAUSE_JUMP;
            state_d = ST_RUN;
        end else if (!imem_ready) begin
            cause   = CAUSE_IMISS;
            state_d = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        ctl = CTL_IDLE;
        if (rst_n) begin
            case (cause)
                CAUSE_FREEZE: begin
                    ctl.stall_f  = 1'b1;
                    ctl.fcd      = 1'b1;
                    ctl.stall_em = 1'b1;
                end
                CAUSE_REDIRECT: begin
                    ctl.b2      = 1'b1;
                    ctl.flush_e = 1'b1;
                end
                CAUSE_JR_WAIT, CAUSE_LOAD_USE, CAUSE_JR_HAZ: begin
                    ctl.stall_f = 1'b1;
                    ctl.fcd     = 1'b1;
                    ctl.flush_e = 1'b1;
                end
                CAUSE_JUMP: begin
                    ctl.b2 = 1'b1;
                end
                CAUSE_IMISS: begin
                    ctl.stall_f = 1'b1;
                    ctl.b2      = 1'b1;
                end
                default: begin
                    ctl = CTL_IDLE;
                end
            endcase
        end
    end

    assign stall_f   = ctl.stall_f;
    assign fcD       = ctl.fcd;
    assign b2        = ctl.b2;
    assign flush_e   = ctl.flush_e;
    assign stall_em  = ctl.stall_em;
    assign flush_any = ctl.b2 | ctl.flush_e;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .clr_n_i (rst_n),
        .inc_i   (ctl.stall_f),
        .count_o (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .clr_n_i (rst_n),
        .inc_i   (flush_any),
        .count_o (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It generates the hold (fcD) and bubble (b2) controls for the IF/ID register, the PC freeze, and the ID/EX flush. It also produces whole-pipe freezes for data-memory wait states. It resolves load-use hazards, the jalr operand hazard (jalr target is computed in ID), taken-branch redirects from EX, and ID-stage jumps. Mealy outputs are driven from the current cycle's inputs plus a small state register that tracks multi-cycle stalls. Two saturating performance counters are included.

## Interface
- no parameters; register-number width fixed at 5, counter width fixed at 16
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- rs1_d, rs2_d  in  5 each  source registers of the instruction in ID
- use_rs1_d, use_rs2_d  in  1 each  ID instruction reads rs1/rs2
- is_jjru_d  in  1  ID holds jal/jalr (unconditional redirect from ID)
- is_jr_d  in  1  ID holds jalr (needs rs1 value in ID)
- rd_e  in  5  destination of the instruction in EX
- wr_e, is_load_e  in  1 each  EX writes rd / EX is a load
- rd_m  in  5  destination of the instruction in MEM
- is_load_m  in  1  MEM is a load
- branch_taken_e  in  1  EX resolved a taken branch
- imem_ready, dmem_ready  in  1 each  memory response valid this cycle
- stall_f  out  1  freeze PC
- fcD  out  1  hold IF/ID contents
- b2  out  1  load bubble into IF/ID
- flush_e  out  1  load bubble into ID/EX
- stall_em  out  1  freeze ID/EX, EX/MEM, MEM/WB
- stall_cnt, flush_cnt  out  16 each  saturating cycle counters

## Operation
- Terms: hitE(r) = wr_e & rd_e≠0 & rd_e==r. hitM(r) = is_load_m & rd_m≠0 & rd_m==r.
- States: RUN, JR_WAIT. Per-cycle priority, highest first:
  1. rst_n=0: all outputs 0, state←RUN, counters←0.
  2. dmem_ready=0 (FREEZE): stall_f=fcD=stall_em=1, b2=flush_e=0. State and counters other than stall_cnt unchanged.
  3. branch_taken_e (REDIRECT): b2=1, flush_e=1, stall_f=0, fcD=0, state←RUN. An ID-stage stall is discarded because ID is wrong-path.
  4. state=JR_WAIT: stall_f=fcD=flush_e=1, state←RUN.
  5. LOAD_USE: is_load_e & (use_rs1_d & hitE(rs1_d) | use_rs2_d & hitE(rs2_d)): stall_f=fcD=flush_e=1. If is_jr_d, state←JR_WAIT (total 2 cycles); otherwise 1 cycle.
  6. JR_HAZ: is_jr_d & (hitE(rs1_d) & ~is_load_e | hitM(rs1_d)): stall_f=fcD=flush_e=1 for one cycle.
  7. JUMP: is_jjru_d with no stall: b2=1 (squash the fall-through fetch).
  8. imem_ready=0: stall_f=1, b2=1 (no valid instruction enters ID).
  9. Otherwise all outputs 0.
- fcD and b2 are never both 1. When a hold applies, it wins over imem bubbles.
- stall_cnt increments on any cycle with stall_f=1. flush_cnt increments on any cycle with b2|flush_e. Both saturate at 16'hFFFF and do not wrap.

## Timing
- All outputs are combinational from inputs and state in the same cycle; pipeline registers act on the next clk edge.
- Load-use stall: 1 cycle. jalr after load in EX: 2 cycles (LOAD_USE then JR_WAIT). jalr after ALU op in EX: 1 cycle. jalr after load in MEM: 1 cycle.
- REDIRECT arriving while in JR_WAIT: the redirect wins, and state returns to RUN the next cycle.
- A FREEZE during JR_WAIT preserves JR_WAIT. The remaining stall cycle executes after dmem_ready returns.
- A held branch_taken_e under FREEZE is acted on in the first cycle after dmem_ready=1.
- Reset asserted mid-stall: state RUN and outputs 0 in that cycle; first post-reset cycle is RUN.

## Structure
- Shared package/defines: state encodings ST_RUN/ST_JR_WAIT, REG_W=5, CNT_W=16, `ZERO_WORD.
- One sub-module, sat_counter (width, increment enable, synchronous active-low clear), instantiated twice.
- Hazard compares stay inline in hazard_ctrl.

## Test plan
- Load-use: lw x5 in EX (rd_e=5, is_load_e=1), ID add rs1=5 -> one cycle stall_f=fcD=flush_e=1, then all 0; stall_cnt=1.
- jalr after load: is_load_e, rd_e=7, is_jr_d, rs1_d=7 -> 2 consecutive stall cycles (RUN→JR_WAIT→RUN); stall_cnt=2.
- x0 immunity: rd_e=0, is_load_e=1, rs1_d=0 -> no stall.
- Redirect over stall: branch_taken_e=1 together with a load-use match -> b2=1, flush_e=1, stall_f=0, fcD=0; flush_cnt=1.
- Memory freeze: dmem_ready=0 for 3 cycles while in JR_WAIT -> stall_em=1 for 3 cycles, then one JR_WAIT stall cycle; stall_cnt=4.
- Saturation and reset: force 70000 stall cycles -> stall_cnt holds 16'hFFFF; rst_n=0 for one cycle -> counters 0 and outputs 0 in that cycle.
